// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU program/data memory port arbiter.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Winner of an IDLE pass; only meaningful when at least one request is high.
  function automatic logic pick_winner(input logic cpu_req, input logic ldr_req,
                                       input logic last_win, input logic rr_en);
    if (cpu_req && ldr_req)
      return rr_en ? ~last_win : REQ_CPU;
    return ldr_req ? REQ_LDR : REQ_CPU;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, registered read, contents never cleared.
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we)
        mem[addr] <= wdata;
      else
        rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU and the loader.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of CPU-first priority.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              rd,
  output logic              wr,
  output logic              busy,
  output logic              addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  state_t            state_reg;
  logic              win_reg;
  logic              last_win_reg;
  logic              we_reg;
  logic              bad_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [1:0]        gnt_reg;
  logic [1:0]        done_reg;
  logic              rd_reg;
  logic              wr_reg;
  logic              busy_reg;
  logic              err_reg;

  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  assign win       = pick_winner(cpu_req, ldr_req, last_win_reg, RR_EN);
  assign sel_we    = (win == REQ_LDR) ? ldr_we    : cpu_we;
  assign sel_addr  = (win == REQ_LDR) ? ldr_addr  : cpu_addr;
  assign sel_wdata = (win == REQ_LDR) ? ldr_wdata : cpu_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      win_reg      <= REQ_CPU;
      last_win_reg <= REQ_LDR;
      we_reg       <= 1'b0;
      bad_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            win_reg      <= win;
            last_win_reg <= win;
            we_reg       <= sel_we;
            addr_reg     <= sel_addr;
            wdata_reg    <= sel_wdata;
            bad_reg      <= (sel_addr >= LIMIT);
            gnt_reg[win] <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          rd_reg    <= ~we_reg;
          wr_reg    <= we_reg & ~bad_reg;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          rd_reg            <= 1'b0;
          wr_reg            <= 1'b0;
          done_reg[win_reg] <= 1'b1;
          err_reg           <= bad_reg;
          state_reg         <= DONE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Reads are launched in GRANT so the RAM output is ready to capture as ACCESS ends;
  // writes use the registered wr strobe, which reset drops before the commit edge.
  assign ram_en = ((state_reg == GRANT) && !we_reg && !bad_reg) || wr_reg;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .en    (ram_en),
    .we    (we_reg),
    .addr  (addr_reg[AW-1:0]),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdata
      logic [DATA_W-1:0] value_reg;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          value_reg <= '0;
        else if ((state_reg == ACCESS) && !we_reg && (win_reg == 1'(gi)))
          value_reg <= bad_reg ? '0 : ram_rdata;
      end
    end
  endgenerate

  assign cpu_gnt   = gnt_reg[REQ_CPU];
  assign ldr_gnt   = gnt_reg[REQ_LDR];
  assign cpu_done  = done_reg[REQ_CPU];
  assign ldr_done  = done_reg[REQ_LDR];
  assign cpu_rdata = g_rdata[0].value_reg;
  assign ldr_rdata = g_rdata[1].value_reg;
  assign rd        = rd_reg;
  assign wr        = wr_reg;
  assign busy      = busy_reg;
  assign addr_err  = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; expected responses come from a memory/arbitration model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_done;
  logic [15:0] cpu_rdata;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [10:0] ldr_addr = '0;
  logic [15:0] ldr_wdata = '0;
  logic        ldr_gnt, ldr_done;
  logic [15:0] ldr_rdata;
  logic        rd, wr, busy, addr_err;

  int total = 0;
  int bad   = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          who;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem_m [64];
  logic [15:0] last_rd [2];
  bit          last_win_m;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
    .rd(rd), .wr(wr), .busy(busy), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic gnt_of(input bit who);
    return who ? ldr_gnt : cpu_gnt;
  endfunction

  function automatic logic done_of(input bit who);
    return who ? ldr_done : cpu_done;
  endfunction

  // Reference model: applies one access in service order and queues its response.
  task automatic model(input bit who, input bit we, input logic [10:0] addr, input logic [15:0] wdata);
    bit err;
    err = (addr >= 11'd64);
    if (we) begin
      if (!err) mem_m[addr[5:0]] = wdata;
    end else begin
      last_rd[who] = err ? 16'h0000 : mem_m[addr[5:0]];
    end
    last_win_m = who;
    q.push_back('{who: who, err: err, rdata: last_rd[who]});
    $display("txn %s %s addr=%0d wdata=%h exp_rdata=%h err=%0d",
             who ? "ldr" : "cpu", we ? "wr" : "rd", addr, wdata, last_rd[who], err);
  endtask

  task automatic set_req(input bit who, input bit we, input logic [10:0] addr, input logic [15:0] wdata);
    if (who) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic drop(input bit who);
    if (who) ldr_req = 1'b0;
    else     cpu_req = 1'b0;
  endtask

  // One request; after the grant the inputs may be changed to show they were latched.
  task automatic single(input bit who, input bit we, input logic [10:0] addr,
                        input logic [15:0] wdata, input bit garble, input logic [10:0] alt);
    @(negedge clock);
    set_req(who, we, addr, wdata);
    model(who, we, addr, wdata);
    @(negedge clock);
    check("gnt", gnt_of(who), 1);
    check("busy", busy, 1);
    if (garble) set_req(who, ~we, alt, 16'($urandom));
    @(negedge clock);
    check("rd", rd, !we);
    check("wr", wr, we && (addr < 11'd64));
    @(negedge clock);
    check("done", done_of(who), 1);
    drop(who);
    @(negedge clock);
    check("idle_busy", busy, 0);
  endtask

  // Both requests rise together; the model decides who is served first.
  task automatic pair(input bit cwe, input logic [10:0] caddr, input logic [15:0] cwd,
                      input bit lwe, input logic [10:0] laddr, input logic [15:0] lwd);
    bit first;
    @(negedge clock);
    set_req(0, cwe, caddr, cwd);
    set_req(1, lwe, laddr, lwd);
    first = RR ? ~last_win_m : 1'b0;
    if (first) begin
      model(1, lwe, laddr, lwd);
      model(0, cwe, caddr, cwd);
    end else begin
      model(0, cwe, caddr, cwd);
      model(1, lwe, laddr, lwd);
    end
    @(negedge clock);
    check("pair_gnt_first", gnt_of(first), 1);
    check("pair_gnt_loser", gnt_of(~first), 0);
    repeat (2) @(negedge clock);
    check("pair_done_first", done_of(first), 1);
    drop(first);
    repeat (2) @(negedge clock);
    check("pair_gnt_second", gnt_of(~first), 1);
    repeat (2) @(negedge clock);
    check("pair_done_second", done_of(~first), 1);
    drop(~first);
    @(negedge clock);
    check("pair_idle_busy", busy, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {cpu_gnt, cpu_done, ldr_gnt, ldr_done, rd, wr, busy, addr_err}, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_ldr_rdata"}, ldr_rdata, 0);
  endtask

  // Monitor: every done pops one expected response.
  always @(negedge clock) begin
    if (!reset) begin
      if (cpu_done || ldr_done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got cpu_done=%0d ldr_done=%0d expected none", cpu_done, ldr_done);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_id", {cpu_done, ldr_done}, e.who ? 2'b01 : 2'b10);
          check("rdata", e.who ? ldr_rdata : cpu_rdata, e.rdata);
          check("addr_err", addr_err, e.err);
        end
      end else if (addr_err) begin
        total++;
        bad++;
        $display("FAIL stray_addr_err: got 1 expected 0 without done");
      end
    end
  end

  initial begin
    logic [10:0] a, b;
    last_rd[0] = '0; last_rd[1] = '0; last_win_m = 1'b1;
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    check_quiet("reset");
    reset = 1'b0;

    // loader write then CPU read-back of address 0
    single(1, 1, 11'd0, 16'h1817, 0, 11'd0);
    single(0, 0, 11'd0, 16'h0000, 0, 11'd0);

    // preload remaining words so every later read has a known value
    for (int i = 1; i < 64; i++)
      single(1, 1, 11'(i), 16'($urandom), i[0], 11'($urandom_range(0, 63)));

    // simultaneous requests, twice in a row, then after a lone CPU access
    pair(0, 11'd5, 16'h0, 1, 11'd6, 16'h1234);
    pair(1, 11'd7, 16'hBEEF, 0, 11'd7, 16'h0);
    single(0, 0, 11'd3, 16'h0, 0, 11'd0);
    pair(0, 11'd8, 16'h0, 0, 11'd9, 16'h0);

    // out-of-range write is suppressed; out-of-range read returns zero
    single(1, 1, 11'd64, 16'hFFFB, 0, 11'd0);
    single(0, 0, 11'd0, 16'h0, 0, 11'd0);
    single(0, 0, 11'd100, 16'h0, 0, 11'd0);
    single(1, 0, 11'd2047, 16'h0, 0, 11'd0);

    // reset during the ACCESS cycle of a write aborts it
    @(negedge clock);
    set_req(1, 1, 11'd22, 16'h0005);
    @(negedge clock);
    check("abort_gnt", ldr_gnt, 1);
    @(negedge clock);
    check("abort_wr", wr, 1);
    reset = 1'b1;
    drop(0);
    drop(1);
    #1;
    check_quiet("abort");
    last_win_m = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clock);
    reset = 1'b0;
    single(0, 0, 11'd22, 16'h0, 0, 11'd0);

    // address changed from 21 to 22 after the grant
    single(0, 1, 11'd21, 16'hAAAA, 0, 11'd0);
    single(0, 1, 11'd22, 16'h5555, 0, 11'd0);
    single(0, 0, 11'd21, 16'h0, 1, 11'd22);
    single(0, 0, 11'd22, 16'h0, 0, 11'd0);

    // randomized mix
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(64, 2047)) : 11'($urandom_range(0, 63));
      b = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(64, 2047)) : 11'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: single(0, 1'($urandom), a, 16'($urandom), 1'($urandom), b);
        1: single(1, 1'($urandom), a, 16'($urandom), 1'($urandom), b);
        default: pair(1'($urandom), a, 16'($urandom), 1'($urandom), b, 16'($urandom));
      endcase
    end

    repeat (3) @(negedge clock);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
